// File: rtl/piano_pkg.sv
// Shared definitions for the piano melody generator: note table,
// note-index type and the half-period helper used to size and fill
// the tone lookup.
package piano_pkg;

    localparam int NUM_NOTES = 8;

    typedef logic [2:0] note_idx_t;

    // Ascending C-major scale, C4..C5, in Hz.
    localparam int NOTE_HZ [NUM_NOTES] = '{262, 294, 330, 349, 392, 440, 494, 523};

    // Clocks per half cycle of a square wave at hz (floored).
    function automatic int half_period(input int clk_hz, input int hz);
        return clk_hz / (2 * hz);
    endfunction

    // Largest half-period in the table; sizes the tone counter.
    function automatic int max_half_period(input int clk_hz);
        int m;
        m = 0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (half_period(clk_hz, NOTE_HZ[i]) > m) begin
                m = half_period(clk_hz, NOTE_HZ[i]);
            end
        end
        return m;
    endfunction

    // Smallest half-period in the table; must stay >= 2.
    function automatic int min_half_period(input int clk_hz);
        int m;
        m = half_period(clk_hz, NOTE_HZ[0]);
        for (int i = 1; i < NUM_NOTES; i++) begin
            if (half_period(clk_hz, NOTE_HZ[i]) < m) begin
                m = half_period(clk_hz, NOTE_HZ[i]);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/piano_tone_divider.sv
// Square-wave tone divider: counts clocks and toggles its output every
// `half` clocks. `clear` and `hold` both force the counter and the
// output to 0; clear wins over a coincident toggle.
module piano_tone_divider #(
    parameter int HALF_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              hold,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              wave_q, wave_d;

    // Next-state: silence/realign, toggle at half-period, else count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q + HALF_W'(1);
        wave_d = wave_q;
        if (clear || hold) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (cnt_q == half - HALF_W'(1)) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
        end
    end

    // Counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/piano.sv
// piano: self-running melody generator. Plays C4..C5 in an endless loop,
// one note per NOTE_CYCLES-clock slot, on the registered square-wave
// output FREQ.
// Optional build macro PIANO_GAP_EN: silences the last GAP_CYCLES clocks
// of every slot (staccato); without it notes play through the slot.
module piano #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int NOTE_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic CLK,
    input  logic RESET,
    output logic FREQ
);

    import piano_pkg::*;

    localparam int HALF_W = $clog2(max_half_period(CLK_HZ) + 1);
    localparam int SLOT_W = (NOTE_CYCLES > 2) ? $clog2(NOTE_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NOTE_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (NOTE_CYCLES <= GAP_CYCLES) begin : g_bad_gap
        $error("piano: NOTE_CYCLES must exceed GAP_CYCLES");
    end
    if (min_half_period(CLK_HZ) < 2) begin : g_bad_half
        $error("piano: CLK_HZ too low, a half-period falls below 2");
    end

    logic [SLOT_W-1:0] slot_q, slot_d;
    note_idx_t         note_idx_q, note_idx_d;
    logic              note_end;
    logic              gap;
    logic [HALF_W-1:0] half_tab [NUM_NOTES];
    logic [HALF_W-1:0] half;

    // Constant half-period table, one entry per note.
    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_half_tab
        assign half_tab[g] = HALF_W'(half_period(CLK_HZ, NOTE_HZ[g]));
    end

    assign half = half_tab[note_idx_q];

    // Slot counter and note sequencing: wrap slot, advance note (7 -> 0).
    always_comb begin
        note_end   = (slot_q == SLOT_LAST);
        slot_d     = slot_q + SLOT_W'(1);
        note_idx_d = note_idx_q;
        if (note_end) begin
            slot_d     = '0;
            note_idx_d = note_idx_q + note_idx_t'(1);
        end
    end

`ifdef PIANO_GAP_EN
    localparam logic [SLOT_W-1:0] GAP_START = SLOT_W'(NOTE_CYCLES - GAP_CYCLES);

    // Gate on the upcoming slot value so FREQ is already 0 during the
    // first clock whose slot count reaches the gap.
    always_comb begin
        gap = (slot_d >= GAP_START);
    end
`else
    // Legato: tone runs through the whole slot.
    always_comb begin
        gap = 1'b0;
    end
`endif

    // Slot and note-index registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_q     <= '0;
            note_idx_q <= '0;
        end else begin
            slot_q     <= slot_d;
            note_idx_q <= note_idx_d;
        end
    end

    // Tone generator; a note boundary realigns it with FREQ low.
    piano_tone_divider #(
        .HALF_W (HALF_W)
    ) u_tone_divider (
        .clk   (CLK),
        .rst   (RESET),
        .clear (note_end),
        .hold  (gap),
        .half  (half),
        .wave  (FREQ)
    );

endmodule

// File: tb/tb_piano.sv
// Self-checking bench for piano with CLK_HZ=100_000, NOTE_CYCLES=2000,
// GAP_CYCLES=200 (half-periods 190,170,151,143,127,113,101,95).
// Expectations cover both builds, selected by PIANO_GAP_EN.
module tb_piano;

    logic clk;
    logic reset;
    logic freq;

    int tests_run;
    int tests_failed;
    int cur;          // rising edges seen since RESET was last released

    piano #(
        .CLK_HZ      (100_000),
        .NOTE_CYCLES (2000),
        .GAP_CYCLES  (200)
    ) dut (
        .CLK   (clk),
        .RESET (reset),
        .FREQ  (freq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIANO_GAP_EN
    localparam bit GAP_BUILD = 1'b1;
`else
    localparam bit GAP_BUILD = 1'b0;
`endif

    typedef struct {
        int   n;          // edges after reset release
        logic exp_legato; // expected FREQ, gap disabled
        logic exp_gap;    // expected FREQ, gap enabled
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input int n, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at edge %0d: FREQ=%b, expected %b", name, n, act, exp);
        end
    endtask

    // Advance to `n` edges after release, then sample 1 time unit later.
    task automatic advance_to(input int n);
        repeat (n - cur) @(posedge clk);
        #1;
        cur = n;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cur          = 0;

        // Hand-computed: FREQ = floor(s/HALF) mod 2 in slot s of each note,
        // forced 0 for s >= 1800 in the gap build.
        vecs.push_back('{0,     1'b0, 1'b0});
        vecs.push_back('{189,   1'b0, 1'b0});
        vecs.push_back('{190,   1'b1, 1'b1});
        vecs.push_back('{379,   1'b1, 1'b1});
        vecs.push_back('{380,   1'b0, 1'b0});
        vecs.push_back('{570,   1'b1, 1'b1});
        vecs.push_back('{1799,  1'b1, 1'b1});
        vecs.push_back('{1800,  1'b1, 1'b0});
        vecs.push_back('{1899,  1'b1, 1'b0});
        vecs.push_back('{1900,  1'b0, 1'b0});
        vecs.push_back('{1999,  1'b0, 1'b0});
        vecs.push_back('{2000,  1'b0, 1'b0});
        vecs.push_back('{2169,  1'b0, 1'b0});
        vecs.push_back('{2170,  1'b1, 1'b1});
        vecs.push_back('{2340,  1'b0, 1'b0});
        vecs.push_back('{4150,  1'b0, 1'b0});
        vecs.push_back('{4151,  1'b1, 1'b1});
        vecs.push_back('{14094, 1'b0, 1'b0});
        vecs.push_back('{14095, 1'b1, 1'b1});
        vecs.push_back('{14190, 1'b0, 1'b0});
        vecs.push_back('{15799, 1'b0, 1'b0});
        vecs.push_back('{15805, 1'b1, 1'b0});
        vecs.push_back('{16000, 1'b0, 1'b0});
        vecs.push_back('{16189, 1'b0, 1'b0});
        vecs.push_back('{16190, 1'b1, 1'b1});
        vecs.push_back('{22500, 1'b1, 1'b1});

        // Reset held for 50 clocks: FREQ low on every cycle.
        reset = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            check("reset_hold", 0, freq, 1'b0);
        end

        // Release on a falling edge; edge 1 is the next rising edge.
        @(negedge clk);
        reset = 1'b0;
        cur   = 0;

        foreach (vecs[i]) begin
            advance_to(vecs[i].n);
            check("play", vecs[i].n, freq, GAP_BUILD ? vecs[i].exp_gap : vecs[i].exp_legato);
        end

        // One-clock reset mid-F4 while FREQ is high.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset", 0, freq, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cur   = 0;
        advance_to(0);
        check("restart", 0, freq, 1'b0);
        advance_to(189);
        check("restart", 189, freq, 1'b0);
        advance_to(190);
        check("restart", 190, freq, 1'b1);
        advance_to(380);
        check("restart", 380, freq, 1'b0);
        advance_to(2170);
        check("restart", 2170, freq, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
